// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit, pairs each
// in-order imem response with its request PC, and presents the head entry to IF/ID.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [31:0]   fetch_pc;
   logic [PW-1:0] rd_ptr, wr_ptr, rq_rd, rq_wr;
   logic [PW-1:0] outstanding, discard, count;
   logic [PW:0]   credit_used;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   rq_pc    [DEPTH];
   logic          req_fire, resp_ok, resp_keep, pop;
   logic          unused_bits;

   assign count       = wr_ptr - rd_ptr;
   assign credit_used = {1'b0, count} + {1'b0, outstanding};

   // Gated by rst so the request strobe drops the instant reset asserts.
   assign imem_req_valid = rst && !redirect && (credit_used < (PW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_ok        = imem_resp_valid && (outstanding != '0);
   assign resp_keep      = resp_ok && (discard == '0) && !redirect;

   assign out_valid = (count != '0);
   assign out_inst  = out_valid ? inst_mem[rd_ptr[AW-1:0]] : 32'h0;
   assign out_pc    = out_valid ? pc_mem[rd_ptr[AW-1:0]]   : 32'h0;
   assign pop       = out_valid && out_ready;

   assign unused_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rq_rd       <= '0;
         rq_wr       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         rq_wr <= rq_wr + PW'(req_fire);
         rq_rd <= rq_rd + PW'(resp_ok);
         if (redirect) begin
            // Everything still in flight after this edge belongs to the dead stream.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - PW'(resp_ok);
            discard     <= outstanding - PW'(resp_ok);
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + PW'(req_fire) - PW'(resp_ok);
            if (resp_ok && (discard != '0))
               discard <= discard - PW'(1);
            if (resp_keep)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire)
         rq_pc[rq_wr[AW-1:0]] <= fetch_pc;
      if (resp_keep) begin
         inst_mem[wr_ptr[AW-1:0]] <= imem_resp_data;
         pc_mem[wr_ptr[AW-1:0]]   <= rq_pc[rq_rd[AW-1:0]];
      end
   end

endmodule
